// File: rtl/risk_engine_mc.sv
// risk_engine_mc: multi-channel exposure risk check between strategy core and order gateway.
// Each accepted (channel, position, beta) update produces exposure e = |pos|*|beta| in
// fixed point. e replaces that channel's table entry, and the running aggregate is updated.
// One verdict is emitted per update. Breaches latch a kill state. Leaving the kill state
// takes an operator clear followed by a cooldown.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        update handshake; ch_in, position_in, beta_in carry the update
//   kill_clear               single-cycle request to leave KILLED
//   out_valid/out_ready      verdict handshake
//   out_ch                   channel of the verdict
//   allow_trade              trade permitted
//   kill_switch              engine is KILLED or in COOLDOWN
//   ch_breach                the exposure for this verdict exceeds LIMIT_CH
//   total_expo               aggregate exposure, unsigned
//   breach_cnt               saturating breach-verdict count (only with RISK_BREACH_CNT_EN)
//
// Optional feature macro: RISK_BREACH_CNT_EN.
`timescale 1ns/1ps
module risk_engine_mc #(
  parameter int unsigned    N_CH      = 4,
  parameter int unsigned    W         = 32,
  parameter int unsigned    FRAC      = 16,
  parameter logic [W-1:0]   LIMIT_CH  = 32'h0032_0000,
  parameter logic [W-1:0]   LIMIT_TOT = 32'h0064_0000,
  parameter int unsigned    COOL_CYC  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(N_CH)-1:0]     ch_in,
  input  logic [W-1:0]                position_in,
  input  logic [W-1:0]                beta_in,
  input  logic                        kill_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(N_CH)-1:0]     out_ch,
  output logic                        allow_trade,
  output logic                        kill_switch,
  output logic                        ch_breach,
  output logic [W+$clog2(N_CH)-1:0]   total_expo
`ifdef RISK_BREACH_CNT_EN
  ,
  output logic [15:0]                 breach_cnt
`endif
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned TW = W + CW;
  localparam int unsigned KW = $clog2(COOL_CYC + 1);
  localparam logic [W-1:0] MaxPos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StNormal, StKilled, StCool} state_e;

  // Absolute value; the most-negative input has no positive twin and clamps to MaxPos.
  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v == MinNeg)  r = MaxPos;
    else if (v[W-1])  r = (~v) + 1'b1;
    else              r = v;
    return r;
  endfunction

  // Pipeline registers
  logic            s1_valid_q;
  logic [CW-1:0]   s1_ch_q;
  logic [W-1:0]    s1_e_q;
  logic            out_valid_q, allow_q, kill_q, chb_q;
  logic [CW-1:0]   out_ch_q;
  logic [TW-1:0]   total_q;
  logic [W-1:0]    expo_q [N_CH];
  state_e          state_q, state_d;
  logic [KW-1:0]   cnt_q, cnt_d;

  // Handshake
  logic s2_adv, s2_fire;
  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s2_fire  = s1_valid_q && s2_adv;

  // S1 arithmetic
  logic [2*W-1:0] prod, prod_sh;
  logic [W-1:0]   e_calc;
  always_comb begin
    prod    = {{W{1'b0}}, abs_sat(position_in)} * {{W{1'b0}}, abs_sat(beta_in)};
    prod_sh = prod >> FRAC;
    e_calc  = (|prod_sh[2*W-1:W-1]) ? MaxPos : prod_sh[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_e_q     <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_ch_q <= ch_in;
        s1_e_q  <= e_calc;
      end
    end
  end

  // S2 table update and breach detection
  logic [TW-1:0] new_total, post_total;
  logic          chb, totb, breach, any_ch_over, clear_ok;
  logic [W-1:0]  ent;
  always_comb begin
    new_total   = total_q - {{CW{1'b0}}, expo_q[s1_ch_q]} + {{CW{1'b0}}, s1_e_q};
    chb         = $signed(s1_e_q) > $signed(LIMIT_CH);
    totb        = new_total > {{CW{1'b0}}, LIMIT_TOT};
    breach      = s2_fire && (chb || totb);
    // Clear eligibility looks at the table and total as they stand after this cycle's write.
    post_total  = s2_fire ? new_total : total_q;
    any_ch_over = 1'b0;
    ent         = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      ent = (s2_fire && (s1_ch_q == CW'(i))) ? s1_e_q : expo_q[i];
      if ($signed(ent) > $signed(LIMIT_CH)) any_ch_over = 1'b1;
    end
    clear_ok = !any_ch_over && (post_total <= {{CW{1'b0}}, LIMIT_TOT});
  end

  // Kill state machine
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StNormal: ;
      StKilled: begin
        if (kill_clear && clear_ok) begin
          state_d = StCool;
          cnt_d   = KW'(COOL_CYC);
        end
      end
      StCool: begin
        if (cnt_q == KW'(1)) begin
          state_d = StNormal;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - KW'(1);
        end
      end
      default: state_d = StNormal;
    endcase
    // A breach overrides any concurrent clear or cooldown expiry.
    if (breach) begin
      state_d = StKilled;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StNormal;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      allow_q     <= 1'b0;
      kill_q      <= 1'b0;
      chb_q       <= 1'b0;
      total_q     <= '0;
      for (int i = 0; i < int'(N_CH); i++) expo_q[i] <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_ch_q        <= s1_ch_q;
        allow_q         <= (state_d == StNormal) && !chb && !totb;
        kill_q          <= (state_d != StNormal);
        chb_q           <= chb;
        total_q         <= new_total;
        expo_q[s1_ch_q] <= s1_e_q;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ch      = out_ch_q;
  assign allow_trade = allow_q;
  assign kill_switch = kill_q;
  assign ch_breach   = chb_q;
  assign total_expo  = total_q;

`ifdef RISK_BREACH_CNT_EN
  logic [15:0] bcnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
    end else if (breach && (bcnt_q != 16'hFFFF)) begin
      bcnt_q <= bcnt_q + 16'd1;
    end
  end
  assign breach_cnt = bcnt_q;
`endif

endmodule

// File: tb/tb_risk_engine_mc.sv
`timescale 1ns/1ps
module tb_risk_engine_mc;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned TW = 34;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, kill_clear, out_valid, out_ready;
  logic [CW-1:0] ch_in, out_ch;
  logic [W-1:0]  position_in, beta_in;
  logic          allow_trade, kill_switch, ch_breach;
  logic [TW-1:0] total_expo;
`ifdef RISK_BREACH_CNT_EN
  logic [15:0]   breach_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  risk_engine_mc dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ch_in       (ch_in),
    .position_in (position_in),
    .beta_in     (beta_in),
    .kill_clear  (kill_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .allow_trade (allow_trade),
    .kill_switch (kill_switch),
    .ch_breach   (ch_breach),
    .total_expo  (total_expo)
`ifdef RISK_BREACH_CNT_EN
    ,
    .breach_cnt  (breach_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; kill_clear = 1'b0; out_ready = 1'b1;
    ch_in = '0; position_in = '0; beta_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drive(input int ch, input logic [W-1:0] pos, input logic [W-1:0] beta);
    in_valid = 1'b1; ch_in = CW'(ch); position_in = pos; beta_in = beta;
  endtask

  task automatic send(input int ch, input logic [W-1:0] pos, input logic [W-1:0] beta);
    int k;
    drive(ch, pos, beta);
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    chk("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int ch, input logic [TW-1:0] tot,
                           input logic al, input logic ki, input logic cb);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ch"}, out_ch, ch);
    chk({tag, "_total"}, total_expo, tot);
    chk({tag, "_allow"}, allow_trade, al);
    chk({tag, "_kill"}, kill_switch, ki);
    chk({tag, "_chb"}, ch_breach, cb);
  endtask

  task automatic get_verdict(input string tag, input int ch, input logic [TW-1:0] tot,
                             input logic al, input logic ki, input logic cb);
    int k;
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    check_out(tag, ch, tot, al, ki, cb);
    tick();
  endtask

  logic [TW-1:0] agg_tot [4] = '{34'h001E_0000, 34'h003C_0000, 34'h005A_0000, 34'h0078_0000};
  logic          agg_al  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [TW-1:0] bp_tot  [4] = '{34'h0001_0000, 34'h0003_0000, 34'h0006_0000, 34'h000A_0000};

  initial begin
    int ii, vi;
    rst = 1'b1;
    do_reset();

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_allow", allow_trade, 0);
    chk("rst_kill", kill_switch, 0);
    chk("rst_chb", ch_breach, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_total", total_expo, 0);
    chk("rst_ready", in_ready, 1);

    // Nominal: 10.0 * 1.5 = 15.0, two-cycle latency
    send(0, 32'h000A_0000, 32'h0001_8000);
    chk("nom_lat1", out_valid, 0);
    tick();
    chk("nom_lat2", out_valid, 1);
    get_verdict("nom", 0, 34'h000F_0000, 1, 0, 0);

    // Aggregate breach: four channels at 30.0 back-to-back
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(c, 32'h001E_0000, 32'h0001_0000);
      else in_valid = 1'b0;
      if (c >= 2) check_out("agg", c - 2, agg_tot[c-2], agg_al[c-2], !agg_al[c-2], 0);
      tick();
    end
    chk("agg_idle", out_valid, 0);

    // Clear refused at total 120.0; after a long wait the engine is still KILLED
    kill_clear = 1'b1; tick(); kill_clear = 1'b0;
    repeat (12) tick();
    send(0, 32'h0001_0000, 32'h0001_0000);
    get_verdict("persist", 0, 34'h005B_0000, 0, 1, 0);

    // Channel breach, then retable the same channel
    send(1, 32'h003C_0000, 32'h0001_0000);
    get_verdict("chb", 1, 34'h0079_0000, 0, 1, 1);
    send(1, 32'h0005_0000, 32'h0001_0000);
    get_verdict("retable", 1, 34'h0042_0000, 0, 1, 0);

    // Accepted clear: verdict on cooldown's last cycle still killed, the next one allowed
    kill_clear = 1'b1; tick(); kill_clear = 1'b0;
    repeat (5) tick();
    drive(2, 32'hFFFF_0000, 32'h0001_0000);
    tick();
    drive(3, 32'h0001_0000, 32'h0001_0000);
    tick();
    in_valid = 1'b0;
    check_out("cool_last", 2, 34'h0025_0000, 0, 1, 0);
    tick();
    check_out("cool_done", 3, 34'h0008_0000, 1, 0, 0);
    tick();
    chk("cool_idle", out_valid, 0);

    // Breach verdict coinciding with kill_clear
    send(0, 32'h003C_0000, 32'h0001_0000);
    get_verdict("brk0", 0, 34'h0043_0000, 0, 1, 1);
    send(0, 32'h0001_0000, 32'h0001_0000);
    get_verdict("fix0", 0, 34'h0008_0000, 0, 1, 0);
    drive(1, 32'h003C_0000, 32'h0001_0000);
    tick();
    in_valid = 1'b0; kill_clear = 1'b1;
    tick();
    kill_clear = 1'b0;
    check_out("simul", 1, 34'h003F_0000, 0, 1, 1);
    tick();
    send(1, 32'h0001_0000, 32'h0001_0000);
    get_verdict("fix1", 1, 34'h0004_0000, 0, 1, 0);
    repeat (12) tick();
    send(2, 32'h0001_0000, 32'h0001_0000);
    get_verdict("still_killed", 2, 34'h0004_0000, 0, 1, 0);

    // Backpressure: out_ready low for five cycles with a continuous input stream
    do_reset();
    out_ready = 1'b0;
    ii = 0; vi = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 5) out_ready = 1'b1;
      #1;
      if (c >= 2 && c < 5) begin
        chk("bp_accepts", ii, 2);
        chk("bp_ready", in_ready, 0);
        check_out("bp_hold", 0, 34'h0001_0000, 1, 0, 0);
      end
      if (out_valid && out_ready) begin
        if (vi < 4) check_out("bp_out", vi, bp_tot[vi], 1, 0, 0);
        else chk("bp_extra", out_valid, 0);
        vi++;
      end
      if (ii < 4) drive(ii, (ii + 1) << 16, 32'h0001_0000);
      else in_valid = 1'b0;
      if (in_valid && in_ready) ii++;
      tick();
    end
    chk("bp_count", vi, 4);

    // Saturation, then reset while updates are in flight
    do_reset();
    send(2, 32'h8000_0000, 32'h7FFF_FFFF);
    get_verdict("sat", 2, 34'h0_7FFF_FFFF, 0, 1, 1);
    drive(1, 32'h000A_0000, 32'h0001_0000);
    tick();
    drive(3, 32'h000A_0000, 32'h0001_0000);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ch", out_ch, 0);
    chk("mid_rst_total", total_expo, 0);
    chk("mid_rst_kill", kill_switch, 0);
    chk("mid_rst_chb", ch_breach, 0);
    chk("mid_rst_allow", allow_trade, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("drop_inflight", out_valid, 0);
      tick();
    end
    send(0, 32'h0002_0000, 32'h0001_0000);
    get_verdict("post_rst", 0, 34'h0002_0000, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/risk_engine_mc.md
Name: risk_engine_mc

Overview:
- Multi-channel successor to the single-position risk check.
- Accepts a stream of per-channel (position, beta) updates and keeps a per-channel exposure table plus a running aggregate exposure.
- Enforces per-channel and aggregate Q16.16 limits through a latched kill state with operator clear and cooldown.
- Sits between the strategy core and the order gateway; emits one verdict per accepted update.

Parameters:
- N_CH, 4: number of channels; power of two, 2..16.
- W, 32: data width; signed fixed point with FRAC fraction bits.
- FRAC, 16: fraction bits (Q16.16 at defaults).
- LIMIT_CH, 32'h0032_0000: per-channel exposure limit (50.0).
- LIMIT_TOT, 32'h0064_0000: aggregate exposure limit (100.0).
- COOL_CYC, 8: cooldown length in clock cycles after a kill clear; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  update valid.
- in_ready  out  1  update accepted when in_valid && in_ready.
- ch_in  in  $clog2(N_CH)  channel index.
- position_in  in  W  signed position.
- beta_in  in  W  signed beta.
- kill_clear  in  1  single-cycle request to leave the kill state.
- out_valid  out  1  verdict valid.
- out_ready  in  1  verdict consumed when out_valid && out_ready.
- out_ch  out  $clog2(N_CH)  channel of this verdict.
- allow_trade  out  1  trade permitted for this update.
- kill_switch  out  1  engine is in KILLED or COOLDOWN after this update.
- ch_breach  out  1  this channel's exposure exceeds LIMIT_CH.
- total_expo  out  W+$clog2(N_CH)  aggregate exposure after this update; unsigned.

Behaviour:
- Reset: async on rst high. out_valid, allow_trade, kill_switch, ch_breach = 0; out_ch = 0; total_expo = 0. Exposure table zeroed. State = NORMAL. Cooldown counter = 0.
- Pipeline has two register stages, S1 (product) and S2 (verdict/update). Latency is 2 cycles from accept to out_valid with no backpressure. Throughput is 1 update per cycle.
- Stall and ready rules:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when S2 advances or S1 is empty.
  - in_ready = S1 empty || S1 advancing; purely combinational from state and out_ready.
  - Held outputs must not change while out_valid && !out_ready.
- S1 arithmetic:
  - e = sat(|pos| * |beta| >> FRAC), computed on a 2W-bit unsigned product.
  - Saturate to 2^(W-1)-1.
  - |most-negative| saturates to 2^(W-1)-1.
- S2 table update and verdict:
  - Read the old entry, then new_total = total - old + e, in W+log2(N_CH) bits. new_total cannot overflow.
  - Write both table[ch] and the total.
  - Back-to-back updates to the same channel read the just-written table value; no stale read.
  - ch_breach = e > LIMIT_CH (signed compare, value is nonnegative).
  - tot_breach = new_total > LIMIT_TOT.
- State machine:
  - NORMAL: if a verdict is produced with ch_breach || tot_breach, go to KILLED.
  - KILLED: on kill_clear with current total <= LIMIT_TOT and no channel entry > LIMIT_CH, go to COOLDOWN and load counter = COOL_CYC. Otherwise ignore the clear.
  - COOLDOWN: decrement every cycle. At 1 go to NORMAL. A breach verdict during cooldown goes to KILLED.
- Verdict outputs:
  - kill_switch = (next state != NORMAL).
  - allow_trade = (next state == NORMAL) && !ch_breach && !tot_breach.
- Simultaneous events:
  - Breach verdict and kill_clear in the same cycle: breach wins, result is KILLED.
  - The clear check uses the total after this cycle's S2 write.
- Updates continue to be accepted and tabled while KILLED; verdicts then carry allow_trade = 0.
- Reset mid-operation drops in-flight S1/S2 contents; no output is produced for them.

Optional Feature:
- Macro RISK_BREACH_CNT_EN.
- Defined:
  - Adds output port breach_cnt, 16 bits.
  - Counts verdicts with ch_breach || tot_breach; saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Nominal path: after reset, ch0 pos = 0x000A0000 (10.0), beta = 0x00018000 (1.5), out_ready = 1. Expect out_valid exactly 2 cycles later with out_ch = 0, total_expo = 0x000F0000, allow_trade = 1, kill_switch = 0, ch_breach = 0.
- Aggregate breach: ch0..ch3 each set to 30.0 exposure (pos 0x001E0000, beta 0x00010000) back-to-back. Expect the first three verdicts to allow trade (totals 30/60/90). The fourth gives total 0x00780000, allow_trade = 0, kill_switch = 1. Kill persists on a subsequent 1.0 update.
- Channel breach and retable:
  - ch1 pos = 0x003C0000 (60.0), beta = 1.0 gives ch_breach = 1, kill_switch = 1.
  - Re-send ch1 pos = 0x00050000: total drops by 55.0 and ch_breach = 0; kill_switch stays 1.
  - Pulse kill_clear: expect exactly COOL_CYC = 8 cycles of COOLDOWN, then the next verdict has allow_trade = 1.
- Clear refused and simultaneous events:
  - kill_clear while total = 120.0: state stays KILLED.
  - Breach verdict coinciding with kill_clear: result is KILLED.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1. Expect in_ready to fall after 2 accepts, out_* stable, no loss or duplication. Release gives in-order verdicts.
- Saturation and reset: pos = 0x80000000, beta = 0x7FFFFFFF gives e saturated to 0x7FFFFFFF and a breach. Assert rst mid-stream: all outputs 0 immediately, table cleared; the first post-reset update yields total equal to its own exposure.
